// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundles the instruction/flag inputs and the datapath
// control outputs of the multi-cycle control unit.
// master: the control unit side (consumes instr/Zero, drives controls).
// slave:  the datapath/memory side (drives instr/Zero, consumes controls).
interface multicycle_ctrl_if #(
    parameter int INSTRET_W = 32
);
    logic [31:0]          instr;
    logic                 Zero;
    logic [3:0]           ALUCtrl;
    logic                 ALUSrc;
    logic                 MemToReg;
    logic                 RegWrite;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 loadPC;
    logic                 PCSrc;
    logic                 illegal;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  instr, Zero,
        output ALUCtrl, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
               loadPC, PCSrc, illegal, instret
    );

    modport slave (
        output instr, Zero,
        input  ALUCtrl, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
               loadPC, PCSrc, illegal, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state (IF/ID/EX/MEM/WB) control unit for an RV32I
// subset core. Instruction-level controls (ALUCtrl/ALUSrc/MemToReg) decode
// straight from instr; strobes are Moore outputs qualified by state.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- when defined, an illegal
// instruction traps into HALT in ID and sets the sticky illegal flag; when
// undefined, illegal instructions retire as NOPs and illegal is tied to 0.
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    multicycle_ctrl_if.master  bus
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] f3_alu;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       mem_to_reg;
    logic       is_r, is_i, is_lw, is_sw, is_beq;
    logic       legal;

    logic       reg_write, mem_read, mem_write, load_pc, pc_src;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];

    // Instruction-level decode: depends only on instr, so stable all instruction.
    always_comb begin
        f3_alu     = ALU_ADD;
        alu_ctrl   = ALU_ADD;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        is_r       = 1'b0;
        is_i       = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_beq     = 1'b0;
        legal      = 1'b0;
        // Shared funct3 map for R-type and I-ALU; 011 (SLTU) has no encoding.
        case (funct3)
            3'b000:  f3_alu = ALU_ADD;
            3'b001:  f3_alu = ALU_SLL;
            3'b010:  f3_alu = ALU_SLT;
            3'b100:  f3_alu = ALU_XOR;
            3'b101:  f3_alu = bus.instr[30] ? ALU_SRA : ALU_SRL;
            3'b110:  f3_alu = ALU_OR;
            3'b111:  f3_alu = ALU_AND;
            default: f3_alu = ALU_ADD;
        endcase
        case (opcode)
            OP_R: begin
                is_r     = 1'b1;
                legal    = (funct3 != 3'b011);
                // Only the register form can become SUB; ADDI never does.
                alu_ctrl = (funct3 == 3'b000 && bus.instr[30]) ? ALU_SUB : f3_alu;
            end
            OP_I: begin
                is_i     = 1'b1;
                legal    = (funct3 != 3'b011);
                alu_ctrl = f3_alu;
                alu_src  = 1'b1;
            end
            OP_LW: begin
                is_lw      = 1'b1;
                legal      = 1'b1;
                alu_src    = 1'b1;
                mem_to_reg = 1'b1;
            end
            OP_SW: begin
                is_sw   = 1'b1;
                legal   = 1'b1;
                alu_src = 1'b1;
            end
            OP_BR: begin
                is_beq   = (funct3 == 3'b000);
                legal    = (funct3 == 3'b000);
                alu_ctrl = ALU_SUB;
            end
            default: legal = 1'b0;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // Next-state, retire counter and state-qualified strobes.
    always_comb begin
        state_d   = state_q;
        instret_d = instret_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        load_pc   = 1'b0;
        pc_src    = 1'b0;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (!legal) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EX;
                end
`else
                state_d = S_EX;
`endif
            end
            S_EX:  state_d = S_MEM;
            S_MEM: begin
                mem_read  = legal && is_lw;
                mem_write = legal && is_sw;
                state_d   = S_WB;
            end
            S_WB: begin
                // Illegal instructions that reach WB retire as NOPs.
                reg_write = legal && (is_r || is_i || is_lw);
                load_pc   = 1'b1;
                pc_src    = legal && is_beq && bus.Zero;
                instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
                state_d   = S_IF;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // State, counter and sticky-flag registers; reset wins in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IF;
            instret_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign bus.ALUCtrl  = alu_ctrl;
    assign bus.ALUSrc   = alu_src;
    assign bus.MemToReg = mem_to_reg;
    assign bus.RegWrite = reg_write;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.loadPC   = load_pc;
    assign bus.PCSrc    = pc_src;
    assign bus.instret  = instret_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal  = illegal_q;
`else
    assign bus.illegal  = 1'b0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RISC-V RV32I-subset core. It sequences each instruction through five states (IF, ID, EX, MEM, WB) and decodes the current instruction word. It drives every control input of the core datapath: ALU operation, operand select, write-back select, register write, PC load and branch select. It also drives the data-memory read/write strobes and keeps a retired-instruction counter.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: clock; all state changes on posedge.
- `rst` in 1: reset. Synchronous, active-high.
- `instr` in 32: current instruction word. Stable from IF through WB, because PC changes only at the end of WB.
- `Zero` in 1: ALU zero flag from the datapath (combinational).
- `ALUCtrl` out 4: ALU operation.
- `ALUSrc` out 1: 1 selects immediate as operand 2.
- `MemToReg` out 1: 1 selects dReadData for write-back.
- `RegWrite` out 1: register-file write enable.
- `MemRead` out 1: data-memory read strobe.
- `MemWrite` out 1: data-memory write strobe.
- `loadPC` out 1: PC update enable.
- `PCSrc` out 1: 1 selects PC+imm; 0 selects PC+4.
- `illegal` out 1: sticky illegal-instruction flag.
- `instret` out INSTRET_W: count of retired instructions.

## Operation
- **State sequence:** IF→ID→EX→MEM→WB→IF, one state per cycle. Every instruction, including an illegal one in NOP mode, takes exactly 5 cycles. The optional HALT state is described under Configuration.
- **Instruction-level decode:** the following outputs depend only on `instr`, not on state, so they are stable for the whole instruction:
  - `ALUCtrl`, `ALUSrc`, `MemToReg`.
- **ALUCtrl encoding:**
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SRL, 1001 SLL, 1010 SRA, 1101 XOR.
- **Supported opcodes:**
  - R-type 0110011: funct3 selects the operation. funct3=000 with instr[30]=1 is SUB, otherwise ADD. funct3=101 with instr[30]=1 is SRA, otherwise SRL.
  - I-ALU 0010011: same funct3 map with ALUSrc=1. ADDI never becomes SUB. SRAI is selected by instr[30].
  - LW 0000011: ADD, ALUSrc=1, MemToReg=1.
  - SW 0100011: ADD, ALUSrc=1.
  - BEQ 1100011 with funct3=000: SUB, ALUSrc=0.
  - Unlisted funct3 values: SLTU is not supported; funct3=011 is illegal.
- **Strobes (state-qualified, one cycle each):**
  - MemRead is 1 in MEM for LW.
  - MemWrite is 1 in MEM for SW.
  - RegWrite is 1 in WB for R-type, I-ALU and LW.
  - loadPC is 1 in WB for every retired instruction.
  - PCSrc is 1 in WB iff the instruction is BEQ and Zero=1. In every other state it is 0.
- **Illegal instruction:** any opcode or funct3 combination not listed above.
- **instret:** increments by 1 on the WB→IF transition. It wraps modulo 2^INSTRET_W.

## Timing
- **Reset:** `rst` sampled high at posedge gives, in the following cycle:
  - state=IF, illegal=0, instret=0.
  - RegWrite, MemRead, MemWrite, loadPC and PCSrc all 0.
- **Reset mid-instruction:** reset has priority in every state. For example, a reset sampled in MEM means MemWrite is 0 in the next cycle and no WB occurs.
- **Strobe latency:** strobes are Moore outputs of the state register and combinational decode. They have zero latency within their state. Because the datapath PC updates at the posedge ending WB, the new PC is visible in the next IF.
- **No stall or handshake:** memory is single-cycle.
- **Outputs in IF/ID/EX:** every strobe is 0.

## Configuration
- Macro: `CTRL_ILLEGAL_TRAP_EN`.
- **Defined:**
  - An illegal instruction in ID transitions to HALT and sets `illegal`=1.
  - HALT holds all strobes at 0 and does not increment instret.
  - HALT is left only by `rst`.
- **Undefined:**
  - An illegal instruction runs as a NOP: all 5 states, no RegWrite/MemRead/MemWrite, loadPC=1 in WB with PCSrc=0, and instret increments.
  - `illegal` is tied to 0.

## Test plan
- **Reset:** assert rst for 2 cycles, release → state IF; all strobes 0; instret=0; illegal=0.
- **ADDI:** instr=0x00500093 (ADDI x1,x0,5) → ALUCtrl=0010 and ALUSrc=1 for all cycles. RegWrite=1 and loadPC=1 only in cycle 5, PCSrc=0. instret=1 after WB.
- **Store then load:**
  - instr=0x0020A223 (SW) → MemWrite=1 only in cycle 4; RegWrite never asserts.
  - instr=0x0040A183 (LW) → MemRead=1 in cycle 4; MemToReg=1; RegWrite=1 in cycle 5.
- **Branch:**
  - BEQ instr=0x00208463 with Zero=1 in WB → PCSrc=1 and loadPC=1, ALUCtrl=0110.
  - Repeated with Zero=0 → PCSrc=0.
- **R-type decode:**
  - 0x40208033 (SUB) → ALUCtrl=0110.
  - 0x4020D033 (SRA) → 1010.
  - 0x0020C033 (XOR) → 1101.
- **Illegal and reset:**
  - instr=0x00000000 with macro → illegal=1 from cycle 3, strobes held at 0 for 20 cycles, instret unchanged. Then rst → IF, illegal=0.
  - Without macro → loadPC=1 in cycle 5, instret+1.
  - Reset asserted during MEM of an SW → MemWrite 0 the next cycle and instret unchanged.
